// File: rtl/execute_muldiv_stage_pkg.sv
// Shared decode constants, ALU operation enum and mult/div operation encoding
// for the registered EX stage.
package execute_muldiv_stage_pkg;

  localparam int unsigned NB_CODE = 6;

  // Primary opcodes
  localparam logic [NB_CODE-1:0] OPC_RTYPE = 6'h00, OPC_BEQ  = 6'h04, OPC_BNE  = 6'h05,
                                 OPC_ADDI  = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A,
                                 OPC_ANDI  = 6'h0C, OPC_ORI  = 6'h0D, OPC_XORI = 6'h0E,
                                 OPC_LUI   = 6'h0F, OPC_LW   = 6'h23, OPC_SW   = 6'h2B;

  // R-type funct codes
  localparam logic [NB_CODE-1:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03,
                                 FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07,
                                 FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                                 FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A,
                                 FN_DIVU = 6'h1B, FN_ADD  = 6'h20, FN_ADDU  = 6'h21,
                                 FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24,
                                 FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
                                 FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV,
    ALU_SRAV, ALU_LUI, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef struct packed {
    logic sign;
    logic is_div;
  } md_op_t;

endpackage

// File: rtl/execute_muldiv_stage_muldiv_iter.sv
// Iterative multiply/divide: one shift-add or restoring step per cycle on
// operand magnitudes, sign fix-up applied to the final step's result.
module execute_muldiv_stage_muldiv_iter
  import execute_muldiv_stage_pkg::*;
#(
  parameter int unsigned NB = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  md_op_t        op,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic          busy,
  output logic          done_c,
  output logic [NB-1:0] hi_c,
  output logic [NB-1:0] lo_c
);

  localparam int unsigned NB_CNT = $clog2(NB);

  logic [NB_CNT-1:0] cnt;
  logic [2*NB-1:0]   acc;
  logic [2*NB-1:0]   acc_next;
  logic [NB-1:0]     opnd;
  logic [NB-1:0]     dividend;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic              a_neg;
  logic              b_neg;
  logic [NB:0]       add_sum;
  logic [NB:0]       rem_sh;
  logic [NB:0]       rem_diff;

  assign a_neg = op.sign & a[NB-1];
  assign b_neg = op.sign & b[NB-1];

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum  = {1'b0, acc[2*NB-1:NB]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*NB-1:NB-1];
    rem_diff = rem_sh - {1'b0, opnd};
    if (!is_div)
      acc_next = {add_sum, acc[NB-1:1]};
    else if (rem_diff[NB])
      acc_next = {rem_sh[NB-1:0], acc[NB-2:0], 1'b0};
    else
      acc_next = {rem_diff[NB-1:0], acc[NB-2:0], 1'b1};
  end

  assign done_c = busy & (cnt == NB_CNT'(NB - 1));

  always_comb begin
    {hi_c, lo_c} = acc_next;
    if (!is_div) begin
      if (neg_q) {hi_c, lo_c} = -acc_next;
    end else if (div_zero) begin
      hi_c = dividend;
      lo_c = '1;
    end else begin
      hi_c = neg_r ? -acc_next[2*NB-1:NB] : acc_next[2*NB-1:NB];
      lo_c = neg_q ? -acc_next[NB-1:0]    : acc_next[NB-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      cnt      <= '0;
      is_div   <= op.is_div;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (b == '0);
      dividend <= a;
      acc      <= op.is_div ? {NB'(0), (a_neg ? -a : a)} : {NB'(0), (b_neg ? -b : b)};
      opnd     <= op.is_div ? (b_neg ? -b : b) : (a_neg ? -a : a);
    end else if (busy) begin
      acc <= acc_next;
      cnt <= cnt + NB_CNT'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_muldiv_stage.sv
// Registered EX stage: decode, ALU, HI/LO registers and result register,
// with a stall towards the hazard unit while the mult/div unit is busy.
module execute_muldiv_stage
  import execute_muldiv_stage_pkg::*;
#(
  parameter int unsigned NB        = 32,
  parameter int unsigned NB_FCODE  = 6,
  parameter int unsigned NB_OPCODE = 6,
  parameter int unsigned NB_SHAMT  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
  input  logic [NB_OPCODE-1:0] i_instruction_op_code,
  input  logic                 i_alu_src,
  input  logic [NB-1:0]        i_data_a,
  input  logic [NB-1:0]        i_data_b,
  input  logic [NB-1:0]        i_immediate_extended,
  input  logic [NB_SHAMT-1:0]  i_shamt,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [NB-1:0]        o_alu_result,
  output logic                 o_cero,
  output logic                 o_md_busy
);

  logic [NB_CODE-1:0] opc;
  logic [NB_CODE-1:0] fn;
  alu_op_e            alu_op;
  md_op_t             md_op;
  logic               is_md;
  logic               is_mf;
  logic               accept;
  logic               md_busy;
  logic               md_done_c;
  logic [NB-1:0]      md_hi_c;
  logic [NB-1:0]      md_lo_c;
  logic [NB-1:0]      hi;
  logic [NB-1:0]      lo;
  logic [NB-1:0]      op_b;
  logic [NB-1:0]      alu_result;

  assign opc = NB_CODE'(i_instruction_op_code);
  assign fn  = NB_CODE'(i_instruction_funct_code);

  always_comb begin
    alu_op = ALU_NONE;
    md_op  = '0;
    is_md  = 1'b0;
    is_mf  = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_SLLV:         alu_op = ALU_SLLV;
          FN_SRLV:         alu_op = ALU_SRLV;
          FN_SRAV:         alu_op = ALU_SRAV;
          FN_MFHI: begin alu_op = ALU_MFHI; is_mf = 1'b1; end
          FN_MFLO: begin alu_op = ALU_MFLO; is_mf = 1'b1; end
          FN_MULT:  begin is_md = 1'b1; md_op.sign = 1'b1; end
          FN_MULTU: is_md = 1'b1;
          FN_DIV:   begin is_md = 1'b1; md_op.sign = 1'b1; md_op.is_div = 1'b1; end
          FN_DIVU:  begin is_md = 1'b1; md_op.is_div = 1'b1; end
          default:  alu_op = ALU_NONE;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: alu_op = ALU_ADD;
      OPC_BEQ, OPC_BNE:                    alu_op = ALU_SUB;
      OPC_ANDI:                            alu_op = ALU_AND;
      OPC_ORI:                             alu_op = ALU_OR;
      OPC_XORI:                            alu_op = ALU_XOR;
      OPC_SLTI:                            alu_op = ALU_SLT;
      OPC_LUI:                             alu_op = ALU_LUI;
      default:                             alu_op = ALU_NONE;
    endcase
  end

  assign op_b = i_alu_src ? i_immediate_extended : i_data_b;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = i_data_a + op_b;
      ALU_SUB:  alu_result = i_data_a - op_b;
      ALU_AND:  alu_result = i_data_a & op_b;
      ALU_OR:   alu_result = i_data_a | op_b;
      ALU_XOR:  alu_result = i_data_a ^ op_b;
      ALU_NOR:  alu_result = ~(i_data_a | op_b);
      ALU_SLT:  alu_result = NB'($signed(i_data_a) < $signed(op_b));
      ALU_SLTU: alu_result = NB'(i_data_a < op_b);
      ALU_SLL:  alu_result = i_data_b << i_shamt;
      ALU_SRL:  alu_result = i_data_b >> i_shamt;
      ALU_SRA:  alu_result = NB'($signed(i_data_b) >>> i_shamt);
      ALU_SLLV: alu_result = i_data_b << i_data_a[NB_SHAMT-1:0];
      ALU_SRLV: alu_result = i_data_b >> i_data_a[NB_SHAMT-1:0];
      ALU_SRAV: alu_result = NB'($signed(i_data_b) >>> i_data_a[NB_SHAMT-1:0]);
      ALU_LUI:  alu_result = i_immediate_extended << (NB / 2);
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  // Only HI/LO consumers and new mult/div ops wait; everything else overlaps
  assign o_stall   = i_valid & md_busy & (is_md | is_mf);
  assign accept    = i_valid & ~o_stall;
  assign o_md_busy = md_busy;

  execute_muldiv_stage_muldiv_iter #(.NB(NB)) u_muldiv (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (accept & is_md),
    .op     (md_op),
    .a      (i_data_a),
    .b      (i_data_b),
    .busy   (md_busy),
    .done_c (md_done_c),
    .hi_c   (md_hi_c),
    .lo_c   (md_lo_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (md_done_c) begin
      hi <= md_hi_c;
      lo <= md_lo_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_alu_result <= '0;
      o_cero       <= 1'b0;
    end else begin
      o_valid <= accept;
      if (accept) begin
        o_alu_result <= alu_result;
        o_cero       <= (alu_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Randomized bench for execute_muldiv_stage against an arithmetic reference
// model of the EX stage, HI/LO and the mult/div busy window.
module tb_execute_muldiv_stage;

  localparam int unsigned NB = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic        alu_src;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] imm;
  logic [4:0]  shamt;
  logic        stall;
  logic        out_valid;
  logic [31:0] result;
  logic        cero;
  logic        md_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          md_end   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic [5:0]  fn_list  [22];
  logic [5:0]  opc_list [11];

  execute_muldiv_stage #(.NB(32), .NB_FCODE(6), .NB_OPCODE(6), .NB_SHAMT(5)) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_valid                  (valid),
    .i_instruction_funct_code (funct),
    .i_instruction_op_code    (opcode),
    .i_alu_src                (alu_src),
    .i_data_a                 (data_a),
    .i_data_b                 (data_b),
    .i_immediate_extended     (imm),
    .i_shamt                  (shamt),
    .o_stall                  (stall),
    .o_valid                  (out_valid),
    .o_alu_result             (result),
    .o_cero                   (cero),
    .o_md_busy                (md_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_md_op(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'h00) && (f inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic is_mf_op(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'h00) && (f inside {6'h10, 6'h12});
  endfunction

  // Expected EX result from the instruction-set rules
  function automatic logic [31:0] ref_alu(input logic [5:0] o, input logic [5:0] f,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] im, input logic [4:0] sh,
                                          input logic src);
    logic [31:0] bo;
    logic [4:0]  vs;
    bo = src ? im : y;
    vs = x[4:0];
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h21: return x + bo;
        6'h22, 6'h23: return x - bo;
        6'h24: return x & bo;
        6'h25: return x | bo;
        6'h26: return x ^ bo;
        6'h27: return ~(x | bo);
        6'h2A: return ($signed(x) < $signed(bo)) ? 32'd1 : 32'd0;
        6'h2B: return (x < bo) ? 32'd1 : 32'd0;
        6'h00: return y << sh;
        6'h02: return y >> sh;
        6'h03: return (y >> sh) | (y[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        6'h04: return y << vs;
        6'h06: return y >> vs;
        6'h07: return (y >> vs) | (y[31] ? ~(32'hFFFF_FFFF >> vs) : 32'd0);
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'd0;
      endcase
    end
    case (o)
      6'h08, 6'h09, 6'h23, 6'h2B: return x + bo;
      6'h04, 6'h05: return x - bo;
      6'h0C: return x & bo;
      6'h0D: return x | bo;
      6'h0E: return x ^ bo;
      6'h0A: return ($signed(x) < $signed(bo)) ? 32'd1 : 32'd0;
      6'h0F: return {im[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    logic sgn;
    sgn = (f == 6'h18) || (f == 6'h1A);
    sx  = sgn ? 64'($signed(x)) : {32'd0, x};
    sy  = sgn ? 64'($signed(y)) : {32'd0, y};
    if (f == 6'h18 || f == 6'h19) begin
      p    = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (y == 32'd0) begin
      m_hi = x;
      m_lo = 32'hFFFF_FFFF;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      m_hi = r[31:0];
      m_lo = q[31:0];
    end
  endtask

  task automatic do_op(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] im,
                       input logic [4:0] sh, input logic src);
    logic        hazard;
    logic        ex_stall;
    logic [31:0] exp;
    hazard = is_md_op(o, f) || is_mf_op(o, f);
    @(negedge clk);
    valid = 1'b1; opcode = o; funct = f; data_a = x; data_b = y;
    imm = im; shamt = sh; alu_src = src;
    forever begin
      #1;
      ex_stall = hazard && (cyc < md_end);
      check($sformatf("%s.stall", name), 32'(stall), 32'(ex_stall));
      @(posedge clk);
      #1;
      if (!ex_stall) break;
      check($sformatf("%s.bubble", name), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    exp = ref_alu(o, f, x, y, im, sh, src);
    check($sformatf("%s.valid", name), 32'(out_valid), 32'd1);
    check($sformatf("%s.result", name), result, exp);
    check($sformatf("%s.cero", name), 32'(cero), 32'(exp == 32'd0));
    if (is_md_op(o, f)) begin
      ref_md(f, x, y);
      md_end = cyc + NB;
    end
    check($sformatf("%s.busy", name), 32'(md_busy), 32'(cyc < md_end));
    valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    fn_list  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A,
                 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    opc_list = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    rst_n = 1'b0; valid = 1'b0; funct = '0; opcode = '0; alu_src = 1'b0;
    data_a = '0; data_b = '0; imm = '0; shamt = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.cero", 32'(cero), 32'd0);
    check("rst.busy", 32'(md_busy), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add",   6'h00, 6'h20, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0);
    do_op("addi",  6'h08, 6'h00, 32'd1, 32'd99, 32'd4, 5'd0, 1'b1);
    do_op("sub",   6'h00, 6'h22, 32'd50, 32'd15, 32'd0, 5'd0, 1'b0);
    do_op("beq",   6'h04, 6'h00, 32'd7, 32'd7, 32'd0, 5'd0, 1'b0);
    do_op("sra",   6'h00, 6'h03, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
    do_op("slt",   6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0);
    do_op("sltu",  6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0);
    do_op("lui",   6'h0F, 6'h00, 32'd0, 32'd0, 32'h0000_1234, 5'd0, 1'b1);
    do_op("undef", 6'h3F, 6'h00, 32'd5, 32'd6, 32'd7, 5'd0, 1'b0);

    do_op("mult",  6'h00, 6'h18, 32'hFFFF_FFFD, 32'd7, 32'd0, 5'd0, 1'b0);
    do_op("mflo",  6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    check("mult.lo", m_lo, 32'hFFFF_FFEB);
    do_op("mfhi",  6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("multu", 6'h00, 6'h19, 32'd5, 32'd6, 32'd0, 5'd0, 1'b0);
    do_op("ovl_add", 6'h00, 6'h20, 32'd3, 32'd4, 32'd0, 5'd0, 1'b0);
    do_op("mult2", 6'h00, 6'h18, 32'd2, 32'd3, 32'd0, 5'd0, 1'b0);
    do_op("mflo2", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    do_op("divu",  6'h00, 6'h1B, 32'd100, 32'd7, 32'd0, 5'd0, 1'b0);
    do_op("divu.lo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("divu.hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("div",   6'h00, 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 1'b0);
    do_op("div.lo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("div.hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("div0",  6'h00, 6'h1A, 32'd5, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("div0.lo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("div0.hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("divmin", 6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0);
    do_op("divmin.lo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("divmin.hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    // Reset in the middle of a divide
    do_op("div_rst", 6'h00, 6'h1A, 32'd1000, 32'd3, 32'd0, 5'd0, 1'b0);
    do_op("add_rst", 6'h00, 6'h20, 32'd9, 32'd9, 32'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; valid = 1'b1; opcode = 6'h00; funct = 6'h12;
    #1;
    check("rst2.valid", 32'(out_valid), 32'd0);
    check("rst2.result", result, 32'd0);
    check("rst2.cero", 32'(cero), 32'd0);
    check("rst2.busy", 32'(md_busy), 32'd0);
    check("rst2.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    md_end = 0; m_hi = '0; m_lo = '0;
    do_op("rst2.mflo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    do_op("rst2.mfhi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o;
      logic [5:0] f;
      int         kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        o = 6'h00;
        f = fn_list[$urandom_range(0, 21)];
      end else if (kind < 8) begin
        o = opc_list[$urandom_range(0, 10)];
        f = 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      do_op("rand", o, f, rnd_val(), rnd_val(), rnd_val(), 5'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
